matrix_scan_controller: RTL and testbench

Time-multiplexed scan controller for the CPLD kit's 5-column × 7-row LED matrix. Takes the three Y-symmetric column images produced by the image decoders (such as the irrigation-mode decoder), mirrors them onto five physical columns and drives one column at a time with a programmable dwell and an anti-ghosting blank gap. Image data is latched once per frame, so a source change never tears a frame. Sits between the image decoders and the matrix pins.

---
 rtl/matrix_pkg.sv | 35 +++
 rtl/matrix_scan_timer.sv | 28 ++
 rtl/matrix_scan_controller.sv | 192 +++++++++++++++++++
 tb/tb_matrix_scan_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, scan FSM encoding and column-mirroring helper for the
// 5x7 LED matrix scan controller.
package matrix_pkg;

  localparam int NUM_COLS = 5;
  localparam int NUM_ROWS = 7;

  localparam logic [NUM_COLS-1:0] COLS_OFF = 5'b11111;
  localparam logic [NUM_ROWS-1:0] ROWS_OFF = 7'b1111111;
  localparam logic [2:0]          LAST_COL = 3'd4;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    DWELL = 2'd1,
    GAP   = 2'd2
  } scan_state_t;

  typedef enum logic [1:0] {
    SRC_COL0 = 2'd0,
    SRC_COL1 = 2'd1,
    SRC_COL2 = 2'd2
  } src_sel_t;

  // Image is Y-symmetric: outer columns share col_2, inner columns share col_1.
  function automatic src_sel_t mirror_col(input logic [2:0] k);
    src_sel_t sel;
    case (k)
      3'd0, 3'd4: sel = SRC_COL2;
      3'd1, 3'd3: sel = SRC_COL1;
      default:    sel = SRC_COL0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero, which
// marks the last cycle of the interval that was loaded.
module matrix_scan_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/matrix_scan_controller.sv
// Time-multiplexed 5x7 LED matrix scanner: per-frame image latch, programmable
// dwell and blank gap. Blink support is compiled in with `define MATRIX_BLINK_EN.
module matrix_scan_controller
  import matrix_pkg::*;
#(
  parameter int SCAN_DIV     = 10000,
  parameter int BLANK_CYCLES = 100
`ifdef MATRIX_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 50
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NUM_ROWS-1:0] col_2,
  input  logic [NUM_ROWS-1:0] col_1,
  input  logic [NUM_ROWS-1:0] col_0,
`ifdef MATRIX_BLINK_EN
  input  logic                blink,
`endif
  output logic [NUM_COLS-1:0] matrix_cols,
  output logic [NUM_ROWS-1:0] matrix_rows,
  output logic                frame_start,
  output logic [1:0]          dbg_state_o
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  scan_state_t         state_q, state_d;
  logic [2:0]          col_q, col_d;
  logic [NUM_ROWS-1:0] img2_q, img1_q, img0_q;
  logic [NUM_ROWS-1:0] img2_d, img1_d, img0_d;
  logic                latch, advance, fs_d;
  logic                t_load, t_clr, t_done;
  logic [CW-1:0]       t_val;
  logic [NUM_COLS-1:0] cols_q, cols_d;
  logic [NUM_ROWS-1:0] rows_q, rows_d, sel_img;
  logic                fs_q;
  logic                dark_d;

  matrix_scan_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .clr_i      (t_clr),
    .load_i     (t_load),
    .load_val_i (t_val),
    .done_o     (t_done)
  );

  // State register; outputs are registered from next-state values so the
  // pins change on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= OFF;
      col_q   <= '0;
      img2_q  <= '0;
      img1_q  <= '0;
      img0_q  <= '0;
      cols_q  <= COLS_OFF;
      rows_q  <= ROWS_OFF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      img2_q  <= img2_d;
      img1_q  <= img1_d;
      img0_q  <= img0_d;
      cols_q  <= cols_d;
      rows_q  <= rows_d;
      fs_q    <= fs_d;
    end
  end

  // Next-state logic; enable=0 wins over any frame boundary.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    latch   = 1'b0;
    advance = 1'b0;
    fs_d    = 1'b0;
    t_load  = 1'b0;
    t_val   = DWELL_LOAD;
    t_clr   = 1'b0;
    if (!enable) begin
      state_d = OFF;
      col_d   = '0;
      t_clr   = 1'b1;
    end else begin
      case (state_q)
        OFF: begin
          state_d = DWELL;
          col_d   = '0;
          latch   = 1'b1;
          fs_d    = 1'b1;
          t_load  = 1'b1;
        end
        DWELL: begin
          if (t_done) begin
            if (BLANK_CYCLES == 0) begin
              advance = 1'b1;
            end else begin
              state_d = GAP;
              t_load  = 1'b1;
              t_val   = GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (t_done) advance = 1'b1;
        end
        default: state_d = OFF;
      endcase
      if (advance) begin
        state_d = DWELL;
        t_load  = 1'b1;
        if (col_q == LAST_COL) begin
          col_d = '0;
          latch = 1'b1;
          fs_d  = 1'b1;
        end else begin
          col_d = col_q + 3'd1;
        end
      end
    end
    img2_d = latch ? col_2 : img2_q;
    img1_d = latch ? col_1 : img1_q;
    img0_d = latch ? col_0 : img0_q;
  end

`ifdef MATRIX_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      phase_q <= phase_d;
    end
  end

  // The frame started from OFF is always frame 0 of a shown half-period.
  always_comb begin
    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (!blink || state_d == OFF) begin
      fcnt_d  = '0;
      phase_d = 1'b0;
    end else if (fs_d && state_q != OFF) begin
      if (int'(fcnt_q) + 1 >= BLINK_FRAMES) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  assign dark_d = phase_d;
`else
  assign dark_d = 1'b0;
`endif

  // Output decode from the next state, column and latched image.
  always_comb begin
    cols_d = COLS_OFF;
    rows_d = ROWS_OFF;
    case (mirror_col(col_d))
      SRC_COL2: sel_img = img2_d;
      SRC_COL1: sel_img = img1_d;
      default:  sel_img = img0_d;
    endcase
    if (state_d == DWELL && !dark_d) begin
      cols_d = ~(NUM_COLS'(1) << col_d);
      rows_d = ~sel_img;
    end
  end

  assign matrix_cols = cols_q;
  assign matrix_rows = rows_q;
  assign frame_start = fs_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Scoreboard bench for matrix_scan_controller: a frame-arithmetic reference
// model pushes the expected pins each cycle, a monitor pops and compares.
module tb_matrix_scan_controller;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYCLES = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int SLOT         = SCAN_DIV + BLANK_CYCLES;
  localparam int FRAME        = 5 * SLOT;

  logic       clk = 1'b0;
  logic       reset, enable, blink;
  logic [6:0] col_2, col_1, col_0;
  logic [4:0] matrix_cols;
  logic [6:0] matrix_rows;
  logic       frame_start;
  logic [1:0] dbg_state;

  logic [12:0] exp_q[$];
  int          tests  = 0;
  int          failed = 0;
  int          cycle  = 0;

  // reference model state
  bit          running = 1'b0;
  int          n       = 0;
  logic [6:0]  img[3];

  logic [6:0]  r2, r1, r0;
  logic        rb;

  always #5 clk = ~clk;

  matrix_scan_controller #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
`ifdef MATRIX_BLINK_EN
    ,
    .BLINK_FRAMES (BLINK_FRAMES)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .col_2       (col_2),
    .col_1       (col_1),
    .col_0       (col_0),
`ifdef MATRIX_BLINK_EN
    .blink       (blink),
`endif
    .matrix_cols (matrix_cols),
    .matrix_rows (matrix_rows),
    .frame_start (frame_start),
    .dbg_state_o (dbg_state)
  );

  // Expected pins after the coming edge, from position within the frame.
  function automatic void model_step();
    logic [4:0] ec;
    logic [6:0] er;
    logic       ef;
    int         p, col, fr, src;
    bit         dark;
    ec = 5'h1f;
    er = 7'h7f;
    ef = 1'b0;
    if (reset || !enable) begin
      running = 1'b0;
    end else begin
      if (!running) begin
        running = 1'b1;
        n = 0;
      end else begin
        n++;
      end
      p   = n % FRAME;
      fr  = n / FRAME;
      col = p / SLOT;
      if (p == 0) begin
        img[0] = col_0;
        img[1] = col_1;
        img[2] = col_2;
      end
      ef   = (p == 0);
      dark = blink && (((fr / BLINK_FRAMES) % 2) == 1);
      src  = (col > 2) ? col - 2 : 2 - col;
      if ((p % SLOT) < SCAN_DIV && !dark) begin
        ec = 5'h1f ^ (5'd1 << col);
        er = ~img[src];
      end
    end
    exp_q.push_back({ef, ec, er});
  endfunction

  task automatic cyc(input logic r, input logic e, input logic [6:0] a2,
                     input logic [6:0] a1, input logic [6:0] a0, input logic b);
    @(negedge clk);
    reset  = r;
    enable = e;
    col_2  = a2;
    col_1  = a1;
    col_0  = a0;
    blink  = b;
    model_step();
  endtask

  // Monitor: every cycle is an output beat.
  initial begin
    logic [12:0] exp, act;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        act = {frame_start, matrix_cols, matrix_rows};
        tests++;
        if (act !== exp) begin
          failed++;
          $display("FAIL pins cyc=%0d fs/cols/rows got %b/%b/%b expected %b/%b/%b",
                   cycle, act[12], act[11:7], act[6:0], exp[12], exp[11:7], exp[6:0]);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; blink = 1'b0;
    col_2 = '0; col_1 = '0; col_0 = '0;

    // reset held with enable high
    repeat (5) cyc(1'b1, 1'b1, 7'h41, 7'h22, 7'h1C, 1'b0);

    // two frames of the reference image, col_0 changes mid-frame 1
    for (int i = 0; i < 70; i++)
      cyc(1'b0, 1'b1, 7'h41, 7'h22, (i >= 10) ? 7'h7F : 7'h1C, 1'b0);

    // drop enable during the column 2 dwell, then re-enable
    repeat (2) cyc(1'b0, 1'b0, 7'h41, 7'h22, 7'h1C, 1'b0);
    repeat (14) cyc(1'b0, 1'b1, 7'h41, 7'h22, 7'h1C, 1'b0);
    cyc(1'b0, 1'b0, 7'h41, 7'h22, 7'h1C, 1'b0);
    repeat (12) cyc(1'b0, 1'b1, 7'h41, 7'h22, 7'h1C, 1'b0);

    // single-cycle reset in the first gap while enabled
    cyc(1'b0, 1'b0, 7'h41, 7'h22, 7'h1C, 1'b0);
    repeat (5) cyc(1'b0, 1'b1, 7'h41, 7'h22, 7'h1C, 1'b0);
    cyc(1'b1, 1'b1, 7'h41, 7'h22, 7'h1C, 1'b0);
    repeat (35) cyc(1'b0, 1'b1, 7'h55, 7'h2A, 7'h63, 1'b0);

`ifdef MATRIX_BLINK_EN
    cyc(1'b0, 1'b0, 7'h41, 7'h22, 7'h1C, 1'b1);
    repeat (200) cyc(1'b0, 1'b1, 7'h41, 7'h22, 7'h1C, 1'b1);
    cyc(1'b0, 1'b0, 7'h41, 7'h22, 7'h1C, 1'b0);
`endif

    // random: rare resets and enable drops, images changing freely
    r2 = 7'h11; r1 = 7'h22; r0 = 7'h33; rb = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic rr, ee;
      rr = ($urandom_range(0, 499) == 0);
      ee = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) r2 = 7'($urandom);
      if ($urandom_range(0, 19) == 0) r1 = 7'($urandom);
      if ($urandom_range(0, 19) == 0) r0 = 7'($urandom);
`ifdef MATRIX_BLINK_EN
      if (rr || !ee) rb = 1'($urandom_range(0, 1));
`endif
      cyc(rr, ee, r2, r1, r0, rb);
    end

    repeat (2) cyc(1'b0, 1'b0, 7'h00, 7'h00, 7'h00, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain left=%0d expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
